// File: rtl/led_pwm_fader.sv
// RGB LED PWM fader: accepts a colour request and ramps each active-low
// channel toward full-on or full-off one LSB per FADE_DIV clocks, while a
// free-running counter turns the levels into a PWM drive.
module led_pwm_fader #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned FADE_DIV = 5500
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [2:0] color_code,
    input  logic       color_valid,
    output logic       color_ready,
    output logic       fade_done,
    output logic [2:0] led
);

    // A divide-by-one still needs a 1-bit divider that simply stays at 0.
    localparam int unsigned DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] MAX      = '1;

    typedef enum logic [0:0] {
        IDLE,
        FADING
    } state_t;

    state_t                   state, state_next;
    logic [2:0][PWM_BITS-1:0] level, target, new_target, stepped_level;
    logic [DIV_W-1:0]         divider;
    logic [PWM_BITS-1:0]      pwm_cnt;
    logic                     accept, step, targets_match, stepped_done;
    logic                     fade_done_next;

    assign color_ready = (state == IDLE);

    // Requested targets and the one-LSB-toward-target candidate levels.
    always_comb begin
        accept        = color_valid && (state == IDLE);
        step          = (state == FADING) && (divider == DIV_LAST);
        targets_match = 1'b1;
        stepped_done  = 1'b1;
        new_target    = '0;
        stepped_level = level;
        for (int unsigned i = 0; i < 3; i++) begin
            new_target[i] = color_code[i] ? '0 : MAX;
            if (level[i] < target[i])
                stepped_level[i] = level[i] + PWM_BITS'(1);
            else if (level[i] > target[i])
                stepped_level[i] = level[i] - PWM_BITS'(1);
            if (new_target[i] != level[i])
                targets_match = 1'b0;
            if (stepped_level[i] != target[i])
                stepped_done = 1'b0;
        end
    end

    // Next-state and fade_done decode.
    always_comb begin
        state_next     = state;
        fade_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (targets_match)
                        fade_done_next = 1'b1;
                    else
                        state_next = FADING;
                end
            end
            FADING: begin
                if (step && stepped_done) begin
                    state_next     = IDLE;
                    fade_done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and registered completion pulse.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            fade_done <= 1'b0;
        end else begin
            state     <= state_next;
            fade_done <= fade_done_next;
        end
    end

    // Targets, fade divider and per-channel levels.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            divider   <= '0;
            level[0]  <= MAX;
            level[1]  <= '0;
            level[2]  <= '0;
            target[0] <= MAX;
            target[1] <= '0;
            target[2] <= '0;
        end else if (accept) begin
            target  <= new_target;
            divider <= '0;
        end else if (state == FADING) begin
            divider <= step ? '0 : divider + DIV_W'(1);
            if (step)
                level <= stepped_level;
        end
    end

    // Free-running PWM counter and registered active-low LED drive.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pwm_cnt <= '0;
            led     <= 3'b110;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            for (int unsigned i = 0; i < 3; i++)
                led[i] <= !(pwm_cnt < level[i]);
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader (PWM_BITS=8, FADE_DIV=4) against a
// closed-form model of levels, readiness, completion and PWM output.
module tb_led_pwm_fader;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [2:0] color_code;
    logic       color_valid;
    logic       color_ready;
    logic       fade_done;
    logic [2:0] led;

    int checks   = 0;
    int failures = 0;

    // Model: cycles since reset, last accept edge, fade start/target levels.
    int cyc;
    int acc_n;
    int done_n;
    int st[3];
    int tg[3];
    bit acc_flag;

    always #5 sys_clk = ~sys_clk;

    led_pwm_fader #(.PWM_BITS(8), .FADE_DIV(4)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .color_code (color_code),
        .color_valid(color_valid),
        .color_ready(color_ready),
        .fade_done  (fade_done),
        .led        (led)
    );

    // Level of a channel after n edges: one LSB per 4 cycles, clamped at target.
    function automatic int exp_level(int ch, int n);
        int k, mag, s;
        if (n <= acc_n) return st[ch];
        k   = (n - acc_n) / 4;
        mag = (tg[ch] > st[ch]) ? tg[ch] - st[ch] : st[ch] - tg[ch];
        s   = (k < mag) ? k : mag;
        return (tg[ch] >= st[ch]) ? st[ch] + s : st[ch] - s;
    endfunction

    function automatic logic [2:0] exp_led(int n);
        logic [2:0] v;
        if (n == 0) return 3'b110;
        for (int ch = 0; ch < 3; ch++)
            v[ch] = !(((n - 1) % 256) < exp_level(ch, n - 1));
        return v;
    endfunction

    function automatic logic exp_ready(int n);
        return !((n > acc_n) && (n < done_n));
    endfunction

    function automatic logic [4:0] exp_vec(int n);
        return {exp_led(n), exp_ready(n), logic'(n == done_n)};
    endfunction

    task automatic model_reset();
        st[0] = 255; st[1] = 0; st[2] = 0;
        tg[0] = 255; tg[1] = 0; tg[2] = 0;
        acc_n  = -100000;
        done_n = -100000;
    endtask

    task automatic model_accept(logic [2:0] code, int a);
        int ns[3];
        int mx;
        mx = 0;
        for (int ch = 0; ch < 3; ch++) ns[ch] = exp_level(ch, a - 1);
        for (int ch = 0; ch < 3; ch++) begin
            st[ch] = ns[ch];
            tg[ch] = code[ch] ? 0 : 255;
            if ((tg[ch] - st[ch]) > mx) mx = tg[ch] - st[ch];
            if ((st[ch] - tg[ch]) > mx) mx = st[ch] - tg[ch];
        end
        acc_n    = a;
        done_n   = a + 4 * mx;
        acc_flag = 1'b1;
    endtask

    // Advance one clock, updating the model from the inputs presented to it.
    task automatic tick();
        int nxt;
        if (sys_rst) begin
            model_reset();
            nxt = 0;
        end else begin
            if (color_valid && exp_ready(cyc)) model_accept(color_code, cyc + 1);
            nxt = cyc + 1;
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc = nxt;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; color_valid = 1'b0; color_code = 3'b111;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({led, color_ready, fade_done} !== 5'b11010) begin
                failures++;
                $display("FAIL reset_values got=%b expected=%b", {led, color_ready, fade_done}, 5'b11010);
            end
        end
        sys_rst = 1'b0;
        tick();
        checks++;
        if (led !== 3'b110) begin
            failures++;
            $display("FAIL first_after_reset led got=%b expected=110", led);
        end
    endtask

    task automatic test_idle_pwm();
        int low;
        low = 0;
        for (int k = 0; k < 512; k++) begin
            tick();
            checks++;
            if ({led, color_ready, fade_done} !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL idle_pwm cyc=%0d got=%b expected=%b", cyc, {led, color_ready, fade_done}, exp_vec(cyc));
            end
            if (!led[0]) low++;
        end
        checks++;
        if (low != 510) begin
            failures++;
            $display("FAIL idle_red_duty low_cycles got=%0d expected=510", low);
        end
    endtask

    task automatic test_same_color();
        color_code = 3'b110; color_valid = 1'b1;
        tick();
        color_valid = 1'b0;
        checks++;
        if ({color_ready, fade_done} !== 2'b11) begin
            failures++;
            $display("FAIL same_color_done ready/done got=%b expected=11", {color_ready, fade_done});
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({led, color_ready, fade_done} !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL same_color cyc=%0d got=%b expected=%b", cyc, {led, color_ready, fade_done}, exp_vec(cyc));
            end
        end
    endtask

    task automatic test_fade_green();
        int a, pulses, at;
        pulses = 0; at = -1;
        color_code = 3'b011; color_valid = 1'b1;
        a = cyc + 1;
        tick();
        color_valid = 1'b0;
        checks++;
        if (color_ready !== 1'b0) begin
            failures++;
            $display("FAIL green_ready_drop got=%b expected=0", color_ready);
        end
        for (int k = 0; k < 1030; k++) begin
            tick();
            checks++;
            if ({led, color_ready, fade_done} !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL green_fade cyc=%0d got=%b expected=%b", cyc, {led, color_ready, fade_done}, exp_vec(cyc));
            end
            if (fade_done) begin pulses++; at = cyc; end
        end
        checks++;
        if (pulses != 1 || at - a != 1020) begin
            failures++;
            $display("FAIL green_done pulses=%0d latency=%0d expected 1 pulse at 1020", pulses, at - a);
        end
    endtask

    task automatic test_hold_during_fade();
        bit seen;
        int pulses;
        seen = 1'b0; pulses = 0;
        color_code = 3'b110; color_valid = 1'b1;
        tick();
        color_valid = 1'b0;
        for (int k = 0; k < 200; k++) tick();
        color_code = 3'b101; color_valid = 1'b1;
        for (int k = 0; k < 2000 && !seen; k++) begin
            tick();
            checks++;
            if ({led, color_ready, fade_done} !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL hold_fade cyc=%0d got=%b expected=%b", cyc, {led, color_ready, fade_done}, exp_vec(cyc));
            end
            if (fade_done === 1'b1) begin
                seen = 1'b1;
                tick();
                color_valid = 1'b0;
                checks++;
                if (color_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL hold_accept_on_done ready got=%b expected=0", color_ready);
                end
            end
        end
        if (!seen) begin
            failures++;
            $display("FAIL hold_timeout fade_done never seen");
            color_valid = 1'b0;
        end
        for (int k = 0; k < 1030; k++) begin
            tick();
            checks++;
            if ({led, color_ready, fade_done} !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL blue_fade cyc=%0d got=%b expected=%b", cyc, {led, color_ready, fade_done}, exp_vec(cyc));
            end
            if (fade_done) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL blue_done pulses got=%0d expected=1", pulses);
        end
    endtask

    task automatic test_reset_mid_fade();
        int pulses;
        pulses = 0;
        color_code = 3'b011; color_valid = 1'b1;
        tick();
        color_valid = 1'b0;
        for (int k = 0; k < 399; k++) tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        checks++;
        if ({led, color_ready, fade_done} !== 5'b11010) begin
            failures++;
            $display("FAIL mid_fade_reset got=%b expected=%b", {led, color_ready, fade_done}, 5'b11010);
        end
        for (int k = 0; k < 1100; k++) begin
            tick();
            checks++;
            if ({led, color_ready, fade_done} !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL after_reset cyc=%0d got=%b expected=%b", cyc, {led, color_ready, fade_done}, exp_vec(cyc));
            end
            if (fade_done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL aborted_fade_done pulses got=%0d expected=0", pulses);
        end
    endtask

    task automatic test_white();
        int a, at;
        int low[3];
        at = -1;
        low[0] = 0; low[1] = 0; low[2] = 0;
        color_code = 3'b000; color_valid = 1'b1;
        a = cyc + 1;
        tick();
        color_valid = 1'b0;
        for (int k = 0; k < 1025; k++) begin
            tick();
            checks++;
            if ({led, color_ready, fade_done} !== exp_vec(cyc)) begin
                failures++;
                $display("FAIL white_fade cyc=%0d got=%b expected=%b", cyc, {led, color_ready, fade_done}, exp_vec(cyc));
            end
            if (fade_done) at = cyc;
        end
        checks++;
        if (at - a != 1020) begin
            failures++;
            $display("FAIL white_done latency got=%0d expected=1020", at - a);
        end
        for (int k = 0; k < 256; k++) begin
            tick();
            for (int ch = 0; ch < 3; ch++) if (!led[ch]) low[ch]++;
        end
        for (int ch = 0; ch < 3; ch++) begin
            checks++;
            if (low[ch] != 255) begin
                failures++;
                $display("FAIL white_duty ch=%0d low_cycles got=%0d expected=255", ch, low[ch]);
            end
        end
    endtask

    task automatic test_random();
        int gap;
        for (int r = 0; r < 4; r++) begin
            gap = $urandom_range(0, 20);
            for (int k = 0; k < gap; k++) tick();
            color_code = 3'($urandom_range(0, 7));
            color_valid = 1'b1;
            acc_flag = 1'b0;
            for (int k = 0; k < 3000 && !acc_flag; k++) tick();
            color_valid = 1'b0;
            if (!acc_flag) begin
                failures++;
                $display("FAIL random_accept_timeout round=%0d", r);
            end
            for (int k = 0; k < 1030; k++) begin
                tick();
                checks++;
                if ({led, color_ready, fade_done} !== exp_vec(cyc)) begin
                    failures++;
                    $display("FAIL random_fade round=%0d cyc=%0d got=%b expected=%b", r, cyc, {led, color_ready, fade_done}, exp_vec(cyc));
                end
            end
        end
    endtask

    initial begin
        sys_rst = 1'b1; color_valid = 1'b0; color_code = 3'b111;
        cyc = 0; acc_flag = 1'b0;
        model_reset();
        test_reset();
        test_idle_pwm();
        test_same_color();
        test_fade_green();
        test_hold_during_fade();
        test_reset_mid_fade();
        test_white();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pwm_fader.md
LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 The block SHALL have parameter PWM_BITS, default 8, meaning the width of the per-channel brightness level and PWM counter.
REQ-002 The block SHALL have parameter FADE_DIV, default 5500, meaning clock cycles per one-LSB fade step (legal range: 1 or more).
REQ-003 The block SHALL have port sys_clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port sys_rst, input, width 1, a synchronous active-high reset.
REQ-005 The block SHALL have port color_code, input, width 3, the requested colour, active-low per channel: bit0=R, bit1=B, bit2=G (3'b110 red, 3'b101 blue, 3'b011 green).
REQ-006 The block SHALL have port color_valid, input, width 1, the request strobe.
REQ-007 The block SHALL have port color_ready, output, width 1, high when a request can be accepted.
REQ-008 The block SHALL have port fade_done, output, width 1, a one-cycle pulse when all channels reach their target.
REQ-009 The block SHALL have port led, output, width 3, the active-low PWM drive to the RGB LED, with the same bit mapping as color_code.

Function
REQ-010 MAX SHALL be defined as 2^PWM_BITS-1; each channel SHALL hold a level[i] and a target[i], both PWM_BITS wide and unsigned.
REQ-011 Accept SHALL occur on a clock edge where color_valid=1 and color_ready=1; otherwise color_code is ignored.
REQ-012 On accept, target[i] SHALL load MAX where color_code[i]=0 and 0 where color_code[i]=1, and the fade divider SHALL clear to 0.
REQ-013 The state machine SHALL have the states IDLE and FADING; color_ready SHALL be 1 in IDLE and 0 in FADING.
REQ-014 IDLE SHALL go to FADING on accept when any computed target[i] differs from level[i].
REQ-015 IDLE SHALL stay in IDLE on accept when all computed targets equal the levels, and fade_done SHALL pulse on the following cycle.
REQ-016 In FADING, the divider SHALL count 0..FADE_DIV-1 and wrap to 0; the step cycle is the one where divider equals FADE_DIV-1.
REQ-017 On a step cycle, each level[i] that differs from target[i] SHALL move by exactly 1 toward it; levels SHALL never overshoot, wrap or saturate past 0 or MAX.
REQ-018 When a step makes all levels equal their targets, the block SHALL return to IDLE on that edge and assert fade_done for exactly the next cycle; color_ready SHALL be 1 in that same cycle.
REQ-019 A full 0 to MAX fade SHALL take MAX*FADE_DIV cycles after accept; channels fading in opposite directions SHALL move simultaneously.
REQ-020 color_valid asserted during FADING SHALL have no effect (no queueing); the requester holds it until color_ready.
REQ-021 pwm_cnt SHALL be a PWM_BITS-wide counter, free-running, incrementing every cycle and wrapping MAX to 0, independent of state.
REQ-022 led[i] SHALL be registered as ~(pwm_cnt < level[i]), giving one cycle of latency; level 0 is always off (1), and level MAX is on for MAX of every 2^PWM_BITS cycles.
REQ-023 When FADE_DIV=1, a step SHALL occur on every FADING cycle.

Reset
REQ-024 Reset SHALL be synchronous active-high on sys_rst, SHALL override all other inputs, and SHALL apply mid-fade by aborting the fade with no fade_done pulse.
REQ-025 Reset values SHALL be: state=IDLE, color_ready=1, fade_done=0, led=3'b110, pwm_cnt=0, divider=0, level and target R=MAX, B=0, G=0 (red on).
REQ-026 In the first cycle after reset, led SHALL remain 3'b110.

Verification (PWM_BITS=8, FADE_DIV=4)
REQ-027 Release reset with no requests for 512 cycles -> led[0] low for 255 of every 256 cycles, led[2:1]=2'b11 constant, color_ready=1, fade_done=0.
REQ-028 Accept 3'b011 (green) -> color_ready=0 next cycle; R falls and G rises one step per 4 cycles; fade_done pulses once exactly 1020 cycles after accept; final levels R=0, G=255, B=0.
REQ-029 Accept 3'b110 while already red -> state stays IDLE, fade_done pulses on the next cycle, levels unchanged.
REQ-030 Hold color_valid with 3'b101 during a fade -> ignored until color_ready=1; accepted on the first ready cycle (the fade_done cycle), then the blue fade begins.
REQ-031 Assert sys_rst at step 100 of a fade -> on the next cycle all reset values hold, no fade_done pulse occurs, and led=3'b110.
REQ-032 Accept 3'b000 (white) from red -> G and B rise together, R stays at 255; fade_done after 1020 cycles; then check the PWM duty of each channel at 255/256.
